// File: rtl/button_event_decoder_if.sv
// Event bus between the button front end and the gesture decoder.
// master drives the timebase tick and debounced level; slave returns gesture pulses.
interface button_event_decoder_if;
  logic tick;
  logic pressed;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic double_click;
  logic held;

  modport master (
    output tick,
    output pressed,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  double_click,
    input  held
  );

  modport slave (
    input  tick,
    input  pressed,
    output short_press,
    output long_press,
    output repeat_pulse,
    output double_click,
    output held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into short, long (with auto-repeat) and
// double-click events, each reported as a registered single-cycle pulse.
module button_event_decoder #(
  parameter int CNT_W        = 8,
  parameter int LONG_TICKS   = 100,
  parameter int DCLICK_TICKS = 25,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    REL_WAIT,
    IDLE,
    DOWN1,
    GAP,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_adv;
  logic             at_long;
  logic             at_dclick;
  logic             at_repeat;

  logic short_q;
  logic long_q;
  logic repeat_q;
  logic dclick_q;
  logic held_q;

  // Tick count when the state is unchanged; saturates so a long hold never wraps.
  assign cnt_adv   = (bus.tick && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
  assign at_long   = bus.tick && (cnt == LONG_LAST);
  assign at_dclick = bus.tick && (cnt == DCLICK_LAST);
  assign at_repeat = bus.tick && (cnt == REPEAT_LAST);

  // Level changes are tested before tick thresholds in every state, so a
  // coincident release/press always wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REL_WAIT;
      cnt      <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      dclick_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case wins,
      // which is what keeps every pulse exactly one cycle wide.
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      dclick_q <= 1'b0;
      held_q   <= (state == LONG);
      cnt      <= cnt_adv;

      unique case (state)
        REL_WAIT: begin
          if (!bus.pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        IDLE: begin
          if (bus.pressed) begin
            state <= DOWN1;
            cnt   <= '0;
          end
        end

        DOWN1: begin
          if (!bus.pressed) begin
            state <= GAP;
            cnt   <= '0;
          end else if (at_long) begin
            state  <= LONG;
            cnt    <= '0;
            long_q <= 1'b1;
            held_q <= 1'b1;
          end
        end

        GAP: begin
          // A second press goes to REL_WAIT so it can never time a long press.
          if (bus.pressed) begin
            state    <= REL_WAIT;
            cnt      <= '0;
            dclick_q <= 1'b1;
          end else if (at_dclick) begin
            state   <= IDLE;
            cnt     <= '0;
            short_q <= 1'b1;
          end
        end

        LONG: begin
          if (!bus.pressed) begin
            state  <= IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
          end else if (at_repeat) begin
            cnt      <= '0;
            repeat_q <= 1'b1;
          end
        end

        default: begin
          state <= REL_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.double_click = dclick_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: main instance with short timing
// parameters, plus a 3-bit counter instance for the saturation scenario.
module tb_button_event_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  button_event_decoder_if bus ();
  button_event_decoder_if sbus ();

  button_event_decoder #(
    .CNT_W(8), .LONG_TICKS(8), .DCLICK_TICKS(4), .REPEAT_TICKS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  button_event_decoder #(
    .CNT_W(3), .LONG_TICKS(7), .DCLICK_TICKS(4), .REPEAT_TICKS(3)
  ) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sbus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed pulse statistics for the main instance.
  int s_cnt, l_cnt, r_cnt, d_cnt, h_cnt;
  int s_cyc, l_cyc, r_first, r_last, d_cyc;
  // Observed pulse statistics for the saturation instance.
  int sl_cnt, sl_cyc, sr_cnt, sr_first, sr_last, so_cnt;

  task automatic clear_counts();
    s_cnt = 0; l_cnt = 0; r_cnt = 0; d_cnt = 0; h_cnt = 0;
    s_cyc = -1; l_cyc = -1; r_first = -1; r_last = -1; d_cyc = -1;
    sl_cnt = 0; sl_cyc = -1; sr_cnt = 0; sr_first = -1; sr_last = -1; so_cnt = 0;
  endtask

  // Apply one cycle of input, then sample outputs 1 ns after the active edge.
  task automatic drive(input logic p, input logic t);
    bus.pressed  = p;
    bus.tick     = t;
    sbus.pressed = p;
    sbus.tick    = t;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.short_press)  begin s_cnt++; s_cyc = cyc; end
    if (bus.long_press)   begin l_cnt++; l_cyc = cyc; end
    if (bus.double_click) begin d_cnt++; d_cyc = cyc; end
    if (bus.repeat_pulse) begin
      if (r_cnt == 0) r_first = cyc;
      r_cnt++;
      r_last = cyc;
    end
    if (bus.held) h_cnt++;
    if (sbus.long_press) begin sl_cnt++; sl_cyc = cyc; end
    if (sbus.repeat_pulse) begin
      if (sr_cnt == 0) sr_first = cyc;
      sr_cnt++;
      sr_last = cyc;
    end
    if (sbus.short_press || sbus.double_click) so_cnt++;
  endtask

  // n tick periods of 4 clk each; the tick lands on the 4th clk of each period.
  task automatic ticks(input int n, input logic p);
    repeat (n) begin
      drive(p, 1'b0);
      drive(p, 1'b0);
      drive(p, 1'b0);
      drive(p, 1'b1);
    end
  endtask

  function automatic logic [4:0] out_vec();
    return {bus.short_press, bus.long_press, bus.repeat_pulse, bus.double_click, bus.held};
  endfunction

  task automatic test_reset();
    clear_counts();
    bus.pressed = 1'b0; bus.tick = 1'b0; sbus.pressed = 1'b0; sbus.tick = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_vec() !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000", out_vec());
    end
    rst_n = 1'b1;
    ticks(2, 1'b0);
    checks++;
    if (s_cnt + l_cnt + r_cnt + d_cnt + h_cnt !== 0) begin
      errors++; $display("FAIL reset_quiet got %0d events exp 0", s_cnt + l_cnt + r_cnt + d_cnt + h_cnt);
    end
  endtask

  task automatic test_short_press();
    int r;
    clear_counts();
    ticks(1, 1'b0);
    ticks(2, 1'b1);
    r = cyc + 1;
    ticks(6, 1'b0);
    checks++;
    if (s_cnt !== 1) begin errors++; $display("FAIL short_count got %0d exp 1", s_cnt); end
    checks++;
    if (s_cyc !== r + 15) begin errors++; $display("FAIL short_timing got %0d exp %0d", s_cyc, r + 15); end
    checks++;
    if (l_cnt + r_cnt + d_cnt + h_cnt !== 0) begin
      errors++; $display("FAIL short_others got %0d exp 0", l_cnt + r_cnt + d_cnt + h_cnt);
    end
  endtask

  task automatic test_long_press();
    int p;
    clear_counts();
    p = cyc + 1;
    ticks(20, 1'b1);
    checks++;
    if (bus.held !== 1'b1) begin errors++; $display("FAIL long_held_level got %b exp 1", bus.held); end
    ticks(2, 1'b0);
    checks++;
    if (l_cnt !== 1) begin errors++; $display("FAIL long_count got %0d exp 1", l_cnt); end
    checks++;
    if (l_cyc !== p + 31) begin errors++; $display("FAIL long_timing got %0d exp %0d", l_cyc, p + 31); end
    checks++;
    if (r_cnt !== 4) begin errors++; $display("FAIL repeat_count got %0d exp 4", r_cnt); end
    checks++;
    if (r_first !== p + 43) begin errors++; $display("FAIL repeat_first got %0d exp %0d", r_first, p + 43); end
    checks++;
    if (r_last !== p + 79) begin errors++; $display("FAIL repeat_last got %0d exp %0d", r_last, p + 79); end
    checks++;
    if (h_cnt !== 49) begin errors++; $display("FAIL held_cycles got %0d exp 49", h_cnt); end
    checks++;
    if (s_cnt + d_cnt !== 0) begin errors++; $display("FAIL long_others got %0d exp 0", s_cnt + d_cnt); end
  endtask

  task automatic test_double_click();
    int d;
    clear_counts();
    ticks(2, 1'b1);
    ticks(2, 1'b0);
    d = cyc + 1;
    ticks(10, 1'b1);
    ticks(3, 1'b0);
    checks++;
    if (d_cnt !== 1) begin errors++; $display("FAIL dclick_count got %0d exp 1", d_cnt); end
    checks++;
    if (d_cyc !== d) begin errors++; $display("FAIL dclick_timing got %0d exp %0d", d_cyc, d); end
    checks++;
    if (s_cnt + l_cnt + r_cnt + h_cnt !== 0) begin
      errors++; $display("FAIL dclick_others got %0d exp 0", s_cnt + l_cnt + r_cnt + h_cnt);
    end
  endtask

  task automatic test_coincidence();
    int s;
    int d;
    clear_counts();
    ticks(7, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    s = cyc + 1;
    ticks(5, 1'b0);
    checks++;
    if (l_cnt + h_cnt !== 0) begin errors++; $display("FAIL release_vs_long got %0d exp 0", l_cnt + h_cnt); end
    checks++;
    if (s_cnt !== 1 || s_cyc !== s + 15) begin
      errors++; $display("FAIL release_vs_long_short got cnt %0d cyc %0d exp cnt 1 cyc %0d", s_cnt, s_cyc, s + 15);
    end

    clear_counts();
    ticks(2, 1'b1);
    ticks(3, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    d = cyc + 1;
    drive(1'b1, 1'b1);
    ticks(2, 1'b1);
    ticks(3, 1'b0);
    checks++;
    if (d_cnt !== 1 || d_cyc !== d) begin
      errors++; $display("FAIL press_vs_timeout got cnt %0d cyc %0d exp cnt 1 cyc %0d", d_cnt, d_cyc, d);
    end
    checks++;
    if (s_cnt !== 0) begin errors++; $display("FAIL press_vs_timeout_short got %0d exp 0", s_cnt); end
  endtask

  task automatic test_reset_mid_gesture();
    int s;
    clear_counts();
    ticks(3, 1'b1);
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_vec() !== 5'b0) begin errors++; $display("FAIL midreset_outputs got %b exp 00000", out_vec()); end
    rst_n = 1'b1;
    ticks(30, 1'b1);
    checks++;
    if (s_cnt + l_cnt + r_cnt + d_cnt + h_cnt !== 0) begin
      errors++; $display("FAIL midreset_absorb got %0d events exp 0", s_cnt + l_cnt + r_cnt + d_cnt + h_cnt);
    end
    ticks(1, 1'b0);
    ticks(2, 1'b1);
    s = cyc + 1;
    ticks(6, 1'b0);
    checks++;
    if (s_cnt !== 1 || s_cyc !== s + 15) begin
      errors++; $display("FAIL midreset_recover got cnt %0d cyc %0d exp cnt 1 cyc %0d", s_cnt, s_cyc, s + 15);
    end

    clear_counts();
    ticks(9, 1'b1);
    checks++;
    if (bus.held !== 1'b1) begin errors++; $display("FAIL longreset_pre_held got %b exp 1", bus.held); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_vec() !== 5'b0) begin errors++; $display("FAIL longreset_outputs got %b exp 00000", out_vec()); end
    rst_n = 1'b1;
    ticks(12, 1'b1);
    ticks(2, 1'b0);
    checks++;
    if (l_cnt !== 1 || r_cnt !== 0 || s_cnt + d_cnt !== 0) begin
      errors++; $display("FAIL longreset_after got long %0d rep %0d other %0d exp 1 0 0", l_cnt, r_cnt, s_cnt + d_cnt);
    end
  endtask

  task automatic test_tick_high();
    int p;
    clear_counts();
    drive(1'b0, 1'b0);
    p = cyc + 1;
    repeat (18) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (l_cnt !== 1 || l_cyc !== p + 8) begin
      errors++; $display("FAIL tickhigh_long got cnt %0d cyc %0d exp cnt 1 cyc %0d", l_cnt, l_cyc, p + 8);
    end
    checks++;
    if (r_cnt !== 3 || r_first !== p + 11 || r_last !== p + 17) begin
      errors++; $display("FAIL tickhigh_repeat got cnt %0d first %0d last %0d exp 3 %0d %0d",
                         r_cnt, r_first, r_last, p + 11, p + 17);
    end
    checks++;
    if (h_cnt !== 10) begin errors++; $display("FAIL tickhigh_held got %0d exp 10", h_cnt); end
  endtask

  task automatic test_saturation();
    int p;
    ticks(12, 1'b0);
    clear_counts();
    p = cyc + 1;
    ticks(50, 1'b1);
    ticks(2, 1'b0);
    checks++;
    if (sl_cnt !== 1 || sl_cyc !== p + 27) begin
      errors++; $display("FAIL sat_long got cnt %0d cyc %0d exp cnt 1 cyc %0d", sl_cnt, sl_cyc, p + 27);
    end
    checks++;
    if (sr_cnt !== 14 || sr_first !== p + 39 || sr_last !== p + 195) begin
      errors++; $display("FAIL sat_repeat got cnt %0d first %0d last %0d exp 14 %0d %0d",
                         sr_cnt, sr_first, sr_last, p + 39, p + 195);
    end
    checks++;
    if (so_cnt !== 0) begin errors++; $display("FAIL sat_others got %0d exp 0", so_cnt); end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_coincidence();
    test_reset_mid_gesture();
    test_tick_high();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
